// File: rtl/bus_master_if.sv
// Single-outstanding req/ack bus master with timeout and misalignment errors.
// Start-to-mem_req 1 cycle, ack-to-pulse 1 cycle; starts arriving while busy are dropped, never queued.
module bus_master_if #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          ALIGN_CHECK    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        BUS_start_transaction,
    input  logic        BUS_mode,
    input  logic [31:0] BUS_addr,
    input  logic [31:0] BUS_wdata,
    output logic [31:0] BUS_rdata,
    output logic        BUS_rdata_valid,
    output logic        BUS_write_done,
    output logic        BUS_error,
    output logic        BUS_busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_rdata_valid;
    logic        r_write_done;
    logic        r_error;
    logic        r_busy;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [7:0]  w_cnt_nxt;
    logic        w_misaligned;

    // Saturating increment keeps the counter from wrapping back under the limit.
    assign w_cnt_nxt    = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_misaligned = ALIGN_CHECK && (BUS_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_rdata       <= 32'd0;
            r_rdata_valid <= 1'b0;
            r_write_done  <= 1'b0;
            r_error       <= 1'b0;
            r_busy        <= 1'b0;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_write_done  <= 1'b0;
            r_error       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (BUS_start_transaction) begin
                        r_we    <= BUS_mode;
                        r_addr  <= {BUS_addr[31:2], 2'b00};
                        r_wdata <= BUS_wdata;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b1;
                        // A rejected access still passes through RESP so busy covers its error pulse.
                        if (w_misaligned) begin
                            r_error <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= S_RESP;
                        if (r_we) begin
                            r_write_done <= 1'b1;
                        end else begin
                            r_rdata       <= mem_rdata;
                            r_rdata_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt >= LP_TIMEOUT) begin
                            r_req   <= 1'b0;
                            r_error <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign BUS_rdata       = r_rdata;
    assign BUS_rdata_valid = r_rdata_valid;
    assign BUS_write_done  = r_write_done;
    assign BUS_error       = r_error;
    assign BUS_busy        = r_busy;
    assign mem_req         = r_req;
    assign mem_we          = r_we;
    assign mem_addr        = r_addr;
    assign mem_wdata       = r_wdata;

endmodule

// File: tb/tb_bus_master_if.sv
// Randomised and directed checks of bus_master_if against a transaction-level outcome model.
module tb_bus_master_if;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, b_start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] addr = '0, wdata = '0, mrdata = '0;
    logic        mack = 1'b0, b_ack = 1'b0;
    logic [31:0] rdata, maddr, mwdata, b_rdata, b_maddr, b_mwdata;
    logic        rvld, wdone, err, busy, mreq, mwe;
    logic        b_rvld, b_wdone, b_err, b_busy, b_mreq, b_mwe;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_rdata = '0;

    always #5 clk = ~clk;

    bus_master_if #(.TIMEOUT_CYCLES(TO), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .BUS_start_transaction(start), .BUS_mode(mode),
        .BUS_addr(addr), .BUS_wdata(wdata), .BUS_rdata(rdata), .BUS_rdata_valid(rvld),
        .BUS_write_done(wdone), .BUS_error(err), .BUS_busy(busy), .mem_req(mreq),
        .mem_we(mwe), .mem_addr(maddr), .mem_wdata(mwdata), .mem_ack(mack), .mem_rdata(mrdata)
    );

    bus_master_if #(.TIMEOUT_CYCLES(TO), .ALIGN_CHECK(1'b0)) dut_noalign (
        .clk(clk), .rst_n(rst_n), .BUS_start_transaction(b_start), .BUS_mode(mode),
        .BUS_addr(addr), .BUS_wdata(wdata), .BUS_rdata(b_rdata), .BUS_rdata_valid(b_rvld),
        .BUS_write_done(b_wdone), .BUS_error(b_err), .BUS_busy(b_busy), .mem_req(b_mreq),
        .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_ack(b_ack), .mem_rdata(mrdata)
    );

    // Called at a falling edge; returns at the falling edge of the cycle after the pulse,
    // so an immediate second call issues a back-to-back start.
    task automatic run_txn(input logic md, input logic [31:0] a, input logic [31:0] wd,
                           input int dly, input logic [31:0] rd, input bit spurious, input string tag);
        int exp_k, exp_req, exp_kind, got_kind, pk, req_cnt, busy_cyc, n_pulse;
        logic [31:0] exp_rdata, rdata_at_pulse;
        // Outcome kinds: 0 read data valid, 1 write done, 2 error.
        if (a[1:0] != 2'b00) begin
            exp_kind = 2; exp_req = 0; exp_k = 1;
        end else if (dly + 1 <= TO) begin
            exp_kind = md ? 1 : 0; exp_req = dly + 1; exp_k = dly + 2;
        end else begin
            exp_kind = 2; exp_req = TO; exp_k = TO + 1;
        end
        exp_rdata = (exp_kind == 0) ? rd : m_rdata;
        pk = 0; req_cnt = 0; busy_cyc = 0; n_pulse = 0; got_kind = -1; rdata_at_pulse = '0;
        mrdata = rd;
        start = 1'b1; mode = md; addr = a; wdata = wd;
        @(negedge clk);
        start = 1'b0;
        if (spurious) begin
            mode = ~md; addr = a ^ 32'h40; wdata = ~wd;
        end
        for (int k = 1; k <= 60 && pk == 0; k++) begin
            start = spurious && (k == 2);
            if (mreq) begin
                req_cnt++;
                n_cmp++;
                if (mwe !== md || maddr !== {a[31:2], 2'b00} || mwdata !== wd) begin
                    n_bad++;
                    $display("FAIL %s req_fields k=%0d got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                             tag, k, mwe, maddr, mwdata, md, {a[31:2], 2'b00}, wd);
                end
                mack = (req_cnt == dly + 1);
            end else begin
                mack = 1'($urandom_range(0, 1));
            end
            if (busy) busy_cyc++;
            if (rvld || wdone || err) begin
                pk = k;
                n_pulse = int'(rvld) + int'(wdone) + int'(err);
                got_kind = rvld ? 0 : (wdone ? 1 : 2);
                rdata_at_pulse = rdata;
                if (spurious) start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0; mack = 1'b0;
        n_cmp++;
        if (pk != exp_k) begin
            n_bad++; $display("FAIL %s pulse_cycle got %0d want %0d", tag, pk, exp_k);
        end
        n_cmp++;
        if (got_kind != exp_kind || n_pulse != 1) begin
            n_bad++; $display("FAIL %s pulse_kind got %0d (n=%0d) want %0d (n=1)", tag, got_kind, n_pulse, exp_kind);
        end
        n_cmp++;
        if (req_cnt != exp_req) begin
            n_bad++; $display("FAIL %s req_cycles got %0d want %0d", tag, req_cnt, exp_req);
        end
        n_cmp++;
        if (busy_cyc != exp_k) begin
            n_bad++; $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_cyc, exp_k);
        end
        n_cmp++;
        if (rdata_at_pulse !== exp_rdata) begin
            n_bad++; $display("FAIL %s bus_rdata got %h want %h", tag, rdata_at_pulse, exp_rdata);
        end
        n_cmp++;
        if ({busy, mreq, rvld, wdone, err} !== 5'b0) begin
            n_bad++; $display("FAIL %s after_resp got busy/req/rv/wd/er=%b want 00000", tag, {busy, mreq, rvld, wdone, err});
        end
        m_rdata = exp_rdata;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rdata, rvld, wdone, err, busy, mreq, mwe, maddr, mwdata} !== '0) begin
            n_bad++; $display("FAIL reset_outputs got rdata=%h busy=%b req=%b addr=%h want all zero", rdata, busy, mreq, maddr);
        end
        n_cmp++;
        if ({b_rdata, b_rvld, b_wdone, b_err, b_busy, b_mreq, b_mwe, b_maddr, b_mwdata} !== '0) begin
            n_bad++; $display("FAIL reset_outputs_noalign got busy=%b req=%b want all zero", b_busy, b_mreq);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_txn(1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, "read_ack0");
        @(negedge clk);
        run_txn(1'b1, 32'h20, 32'h12345678, 5, 32'h55AA55AA, 1'b0, "write_dly5");
        @(negedge clk);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h40, 32'h0, 16, 32'h11112222, 1'b0, "read_timeout");
        @(negedge clk);
        run_txn(1'b0, 32'h44, 32'h0, 2, 32'hA5A5F00F, 1'b0, "read_after_to");
        @(negedge clk);
        run_txn(1'b1, 32'h48, 32'hCCCC0000, 15, 32'h0, 1'b0, "ack_at_limit");
        @(negedge clk);
        run_txn(1'b1, 32'h4C, 32'h1, 40, 32'h0, 1'b0, "write_timeout");
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        bit done;
        run_txn(1'b0, 32'h103, 32'h0, 0, 32'h99999999, 1'b0, "misaligned_rd");
        @(negedge clk);
        done = 1'b0;
        mrdata = 32'hCAFEF00D;
        b_start = 1'b1; mode = 1'b0; addr = 32'h103;
        @(negedge clk);
        b_start = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            b_ack = 1'b0;
            if (b_mreq) begin
                n_cmp++;
                if (b_maddr !== 32'h100) begin
                    n_bad++; $display("FAIL noalign_mem_addr got %h want 00000100", b_maddr);
                end
                b_ack = 1'b1;
            end
            if (b_rvld || b_err || b_wdone) done = 1'b1;
            if (!done) @(negedge clk);
        end
        b_ack = 1'b0;
        n_cmp++;
        if (!(done && b_rvld && !b_err && b_rdata === 32'hCAFEF00D)) begin
            n_bad++; $display("FAIL noalign_complete got rv=%b er=%b rdata=%h want rv=1 er=0 rdata=cafef00d", b_rvld, b_err, b_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 32'h200, 32'h0, 3, 32'h0BADCAFE, 1'b1, "b2b_0");
        run_txn(1'b1, 32'h204, 32'h76543210, 0, 32'h0, 1'b1, "b2b_1");
        run_txn(1'b0, 32'h208, 32'h0, 0, 32'h13572468, 1'b0, "b2b_2");
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; mode = 1'b0; addr = 32'h300; mrdata = 32'hFFFF0000;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mreq !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_req got %b want 1", mreq);
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mreq, busy, rvld, wdone, err} !== 5'b0 || rdata !== 32'h0) begin
            n_bad++; $display("FAIL async_reset got req/busy/rv/wd/er=%b rdata=%h want 00000 0", {mreq, busy, rvld, wdone, err}, rdata);
        end
        m_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({mreq, busy, rvld, wdone, err} !== 5'b0) begin
            n_bad++; $display("FAIL post_release_idle got %b want 00000", {mreq, busy, rvld, wdone, err});
        end
        run_txn(1'b0, 32'h304, 32'h0, 2, 32'h600DF00D, 1'b0, "read_after_rst");
        @(negedge clk);
    endtask

    task automatic test_random();
        logic        md;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            md = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_txn(md, a, $urandom, int'($urandom_range(0, 19)), $urandom,
                    1'($urandom_range(0, 1)), $sformatf("rand_%0d", i));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
